ashr_inv_solve_ctrl: RTL and testbench
======================================

Name: ashr_inv_solve_ctrl

Overview:
- Sequencing controller that shares one combinational Skolem-function instance among NREQ requesters.
- The Skolem function solves x >>a s == t for 4-bit s, t.
- Each granted query is run through the Skolem function, and the candidate x is checked against an arithmetic-shift model. The block returns x, a solved/unsolvable flag and the requester id.
- Sits between the invertibility-query producers and the Skolem datapath. It also keeps saturating solved/failed statistics.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of requester id; must equal clog2(NREQ)
- CW, 8, width of each statistics counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester query valid
- req_s  in  4*NREQ  shift amount s, requester k at bits [4k+3:4k], unsigned
- req_t  in  4*NREQ  target t, requester k at bits [4k+3:4k]
- req_ready  out  NREQ  one-hot accept; at most one bit high per cycle
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumer ready
- resp_id  out  IDW  id of the requester being answered
- resp_x  out  4  Skolem candidate x
- resp_ok  out  1  1 iff (resp_x >>a s) == t
- cnt_ok  out  CW  count of responses with ok=1, saturating
- cnt_fail  out  CW  count of responses with ok=0, saturating
- cnt_clr  in  1  synchronous clear of both counters

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rr_ptr=0.
  - req_ready=0, resp_valid=0, resp_id=0, resp_x=0, resp_ok=0, cnt_ok=0, cnt_fail=0.
  - Reset mid-query aborts the query; it is never answered.
- FSM IDLE -> EVAL -> CHECK -> RESP -> IDLE.
- IDLE:
  - Round-robin search of req_valid starting at rr_ptr, wrapping at NREQ-1 -> 0.
  - The first valid index g gets req_ready[g]=1 combinationally in this cycle; no other ready bit is high.
  - On that edge, register s_r, t_r, id_r=g, then go to EVAL. If no req_valid bit is set, stay in IDLE.
- EVAL: x_r <= skolem(s_r, t_r). Go to CHECK.
- CHECK: ok_r <= (ashr4(x_r, s_r) == t_r). Go to RESP.
- ashr4 rules:
  - s >= 4 gives {4{x[3]}}.
  - Otherwise arithmetic right shift with the sign bit replicated.
  - s is unsigned 4-bit.
- RESP:
  - resp_valid=1; resp_id, resp_x, resp_ok driven from registers and held stable until resp_ready=1.
  - On the handshake edge:
    - cnt_ok or cnt_fail increments by 1, saturating at 2^CW-1.
    - rr_ptr <= (id_r+1) mod NREQ.
    - Go to IDLE.
  - req_ready is all 0 in EVAL, CHECK and RESP.
- Latency: accept edge at cycle 0; resp_valid first high in cycle 3. Minimum issue interval is 4 cycles (a new accept is possible in the cycle after the response handshake).
- resp_x is not meaningful when resp_ok=0; the bench checks only resp_ok in that case.
- cnt_clr=1 clears both counters on the edge. Clear wins over a simultaneous increment.
- A requester that drops req_valid before it is granted is simply skipped; there is no memory of requests.

Decomposition:
- Shared package ashr_inv_pkg holds:
  - the FSM state enum (IDLE, EVAL, CHECK, RESP);
  - constant W=4;
  - a function ashr4(x, s), also used by the bench scoreboard.
- Sub-module skolem_ashr4: combinational, ports s[3:0], t[3:0] -> x[3:0]. It is instantiated once inside the controller. Arbitration, checking and counters stay in the top level.

Test Plan:
- Solvable query: req_valid[0]=1, s=1, t=4'b0011 -> req_ready[0] high in cycle 0; resp_valid in cycle 3 with resp_id=0, resp_x in {0110, 0111}, resp_ok=1; cnt_ok=1.
- Unsolvable, bit mismatch: s=1, t=4'b1000 -> resp_ok=0, cnt_fail=1. Unsolvable, large shift: s=5, t=4'b0101 -> resp_ok=0.
- Large shift, solvable: s=5, t=4'b1111 -> resp_ok=1 and resp_x[3]=1. With s=4, t=0000 -> resp_ok=1 and resp_x[3]=0.
- Fairness: all four req_valid held high from reset -> grants in order 0,1,2,3,0. Accepts are exactly 4 cycles apart with resp_ready=1. Never two req_ready bits high at once.
- Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid/id/x/ok stable, all req_ready=0, counters unchanged. Raising resp_ready completes the handshake, and the next accept occurs in the following cycle.
- Reset and counters:
  - rst pulsed during EVAL -> all outputs 0 in the same cycle; no response is produced; the next grant starts from requester 0.
  - With CW=2, five ok responses -> cnt_ok=3.
  - cnt_clr coinciding with a handshake -> cnt_ok=0.

Source files
------------

// File: rtl/ashr_inv_solve_ctrl_pkg.sv
// Shared definitions for the arithmetic-shift invertibility controller:
// FSM states, datapath width and the 4-bit arithmetic-shift model.
package ashr_inv_pkg;

  localparam int unsigned W = 4;

  typedef enum logic [1:0] {IDLE, EVAL, CHECK, RESP} state_t;

  // Shift amounts of 4 or more leave only copies of the sign bit.
  function automatic logic [W-1:0] ashr4(input logic [W-1:0] x, input logic [W-1:0] s);
    logic signed [W-1:0] xs;
    logic [W-1:0]        r;
    xs = signed'(x);
    if (s[3:2] != 2'b00) begin
      r = {W{x[W-1]}};
    end else begin
      r = xs >>> s[1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/ashr_inv_solve_ctrl_if.sv
// Query/response bundle between the requesters, the consumer and the controller.
interface ashr_inv_solve_ctrl_if
  import ashr_inv_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [W*NREQ-1:0] req_s;
  logic [W*NREQ-1:0] req_t;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_x;
  logic              resp_ok;

  modport master (
    output req_valid, req_s, req_t, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_x, resp_ok
  );

  modport slave (
    input  req_valid, req_s, req_t, resp_ready,
    output req_ready, resp_valid, resp_id, resp_x, resp_ok
  );
endinterface

// File: rtl/ashr_inv_solve_ctrl_skolem.sv
// Combinational Skolem candidate for x >>a s == t; the controller verifies the
// candidate, so an unsolvable (s, t) may yield any x.
module skolem_ashr4
  import ashr_inv_pkg::*;
(
  input  logic [W-1:0] s,
  input  logic [W-1:0] t,
  output logic [W-1:0] x
);

  // For large shifts the result is pure sign fill, so x = t works exactly when
  // t is all-zeros or all-ones; otherwise shifting t back left is the only candidate.
  always_comb begin
    x = '0;
    if (s[3:2] != 2'b00) begin
      x = t;
    end else begin
      x = t << s[1:0];
    end
  end

endmodule

// File: rtl/ashr_inv_solve_ctrl.sv
// Round-robin sequencer sharing one Skolem instance among NREQ requesters,
// checking each candidate and keeping saturating solved/failed counts.
module ashr_inv_solve_ctrl
  import ashr_inv_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned CW   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  ashr_inv_solve_ctrl_if.slave   bus,
  input  logic                   cnt_clr,
  output logic [CW-1:0]          cnt_ok,
  output logic [CW-1:0]          cnt_fail
);

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr, id_r, gnt_idx, cand;
  logic           found;
  logic [W-1:0]   s_r, t_r, x_r, x_sk, s_sel, t_sel;
  logic           ok_r;
  logic           hs;

  skolem_ashr4 u_skolem (
    .s (s_r),
    .t (t_r),
    .x (x_sk)
  );

  // First valid requester at or after rr_ptr, wrapping at NREQ-1.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IDW'((32'(rr_ptr) + i) % NREQ);
      if (!found && bus.req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign s_sel = bus.req_s[{gnt_idx, 2'b00} +: W];
  assign t_sel = bus.req_t[{gnt_idx, 2'b00} +: W];
  assign hs    = (state == RESP) && bus.resp_ready;

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = '0;
    bus.resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          bus.req_ready[gnt_idx] = 1'b1;
          state_nxt              = EVAL;
        end
      end
      EVAL:  state_nxt = CHECK;
      CHECK: state_nxt = RESP;
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      id_r   <= '0;
      s_r    <= '0;
      t_r    <= '0;
      x_r    <= '0;
      ok_r   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) begin
        s_r  <= s_sel;
        t_r  <= t_sel;
        id_r <= gnt_idx;
      end
      if (state == EVAL)  x_r  <= x_sk;
      if (state == CHECK) ok_r <= (ashr4(x_r, s_r) == t_r);
      if (hs) rr_ptr <= (id_r == IDW'(NREQ - 1)) ? '0 : id_r + IDW'(1);
    end
  end

  // Clear takes priority over an increment on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_ok   <= '0;
      cnt_fail <= '0;
    end else if (cnt_clr) begin
      cnt_ok   <= '0;
      cnt_fail <= '0;
    end else if (hs) begin
      if (ok_r) begin
        if (cnt_ok != '1) cnt_ok <= cnt_ok + 1'b1;
      end else begin
        if (cnt_fail != '1) cnt_fail <= cnt_fail + 1'b1;
      end
    end
  end

  assign bus.resp_id = id_r;
  assign bus.resp_x  = x_r;
  assign bus.resp_ok = ok_r;

endmodule

// File: tb/tb_ashr_inv_solve_ctrl.sv
// Directed and randomized checks of the shift-solve controller against a
// brute-force solvability model and a round-robin grant model.
module tb_ashr_inv_solve_ctrl;
  import ashr_inv_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;
  localparam int unsigned CW   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cnt_clr, cnt_clr2;
  logic [CW-1:0] cnt_ok, cnt_fail;
  logic [1:0]    cnt_ok2, cnt_fail2;

  int ncmp  = 0;
  int nfail = 0;
  int m_ok, m_fail, m_ptr;
  int fs[NREQ];
  int ft[NREQ];

  ashr_inv_solve_ctrl_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
  ashr_inv_solve_ctrl_if #(.NREQ(NREQ), .IDW(IDW)) bus2 ();

  ashr_inv_solve_ctrl #(.NREQ(NREQ), .IDW(IDW), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .cnt_clr  (cnt_clr),
    .cnt_ok   (cnt_ok),
    .cnt_fail (cnt_fail)
  );

  ashr_inv_solve_ctrl #(.NREQ(NREQ), .IDW(IDW), .CW(2)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus2),
    .cnt_clr  (cnt_clr2),
    .cnt_ok   (cnt_ok2),
    .cnt_fail (cnt_fail2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Arithmetic shift on the two's-complement value as a plain integer.
  function automatic logic [3:0] ref_ashr(input int x, input int s);
    int v;
    v = (x >= 8) ? x - 16 : x;
    v = v >>> s;
    return 4'(v & 15);
  endfunction

  function automatic bit ref_solvable(input int s, input int t);
    for (int x = 0; x < 16; x++) begin
      if (int'(ref_ashr(x, s)) == t) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_count(input bit ok, input bit clr);
    if (clr) begin
      m_ok   = 0;
      m_fail = 0;
    end else if (ok) begin
      if (m_ok < 255) m_ok++;
    end else begin
      if (m_fail < 255) m_fail++;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"},    bus.req_ready, 0);
    chk({tag, "_valid"},    bus.resp_valid, 0);
    chk({tag, "_id"},       bus.resp_id, 0);
    chk({tag, "_x"},        bus.resp_x, 0);
    chk({tag, "_ok"},       bus.resp_ok, 0);
    chk({tag, "_cnt_ok"},   cnt_ok, 0);
    chk({tag, "_cnt_fail"}, cnt_fail, 0);
  endtask

  // Entered at posedge+1 in IDLE; returns at posedge+1 after the handshake edge.
  task automatic run_query(input int k, input int s, input int t, input int hold, input bit clr);
    bit             eok;
    logic [3:0]     x0;
    logic [IDW-1:0] id0;
    logic           ok0;
    eok = ref_solvable(s, t);
    bus.req_valid           = '0;
    bus.req_valid[k]        = 1'b1;
    bus.req_s[4*k +: 4]     = 4'(s);
    bus.req_t[4*k +: 4]     = 4'(t);
    #1;
    chk("grant", bus.req_ready, 32'(1) << k);
    @(posedge clk); #1;
    bus.req_valid = '0;
    chk("ready_eval", bus.req_ready, 0);
    chk("valid_eval", bus.resp_valid, 0);
    @(posedge clk); #1;
    chk("valid_check", bus.resp_valid, 0);
    @(posedge clk); #1;
    chk("valid_resp", bus.resp_valid, 1);
    chk("resp_id", bus.resp_id, k);
    chk("resp_ok", bus.resp_ok, eok);
    if (eok) chk("resp_x_solves", ref_ashr(bus.resp_x, s), t);
    x0  = bus.resp_x;
    id0 = bus.resp_id;
    ok0 = bus.resp_ok;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      chk("bp_valid", bus.resp_valid, 1);
      chk("bp_x", bus.resp_x, x0);
      chk("bp_id", bus.resp_id, id0);
      chk("bp_ok", bus.resp_ok, ok0);
      chk("bp_ready", bus.req_ready, 0);
      chk("bp_cnt_ok", cnt_ok, m_ok);
      chk("bp_cnt_fail", cnt_fail, m_fail);
    end
    bus.resp_ready = 1'b1;
    cnt_clr        = clr;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    cnt_clr        = 1'b0;
    model_count(eok, clr);
    m_ptr = (k + 1) % NREQ;
    chk("hs_valid", bus.resp_valid, 0);
    chk("hs_cnt_ok", cnt_ok, m_ok);
    chk("hs_cnt_fail", cnt_fail, m_fail);
  endtask

  initial begin
    int g;
    rst            = 1'b1;
    cnt_clr        = 1'b0;
    cnt_clr2       = 1'b0;
    bus.req_valid  = '0;
    bus.req_s      = '0;
    bus.req_t      = '0;
    bus.resp_ready = 1'b0;
    bus2.req_valid  = '0;
    bus2.req_s      = '0;
    bus2.req_t      = '0;
    bus2.resp_ready = 1'b0;
    m_ok = 0; m_fail = 0; m_ptr = 0;
    #1;
    chk_zero("reset");

    for (int x = 0; x < 16; x++) begin
      for (int s = 0; s < 16; s++) begin
        chk("pkg_ashr4", ashr4(4'(x), 4'(s)), ref_ashr(x, s));
      end
    end

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed solvable / unsolvable / large-shift cases.
    run_query(0, 1, 4'b0011, 0, 1'b0);
    chk("first_cnt_ok", cnt_ok, 1);
    run_query(1, 1, 4'b1000, 0, 1'b0);
    chk("mismatch_cnt_fail", cnt_fail, 1);
    run_query(2, 5, 4'b0101, 0, 1'b0);
    run_query(3, 5, 4'b1111, 0, 1'b0);
    chk("s5_x_sign", bus.resp_x[3], 1);
    run_query(0, 4, 4'b0000, 0, 1'b0);
    chk("s4_x_sign", bus.resp_x[3], 0);

    // Backpressure, then an immediate follow-on accept.
    run_query(1, 2, 4'b1110, 5, 1'b0);
    run_query(2, 0, 4'b1001, 0, 1'b0);

    // Clear coinciding with a handshake.
    run_query(3, 1, 4'b0011, 0, 1'b1);

    for (int i = 0; i < 24; i++) begin
      run_query(int'($urandom_range(0, NREQ - 1)), int'($urandom_range(0, 5)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 2)), 1'b0);
    end

    // Fairness from reset with every requester asserting.
    rst = 1'b1;
    #1;
    chk_zero("reset2");
    @(posedge clk); #1;
    rst = 1'b0;
    m_ok = 0; m_fail = 0; m_ptr = 0;
    for (int k = 0; k < NREQ; k++) begin
      fs[k] = int'($urandom_range(0, 5));
      ft[k] = int'($urandom_range(0, 15));
      bus.req_s[4*k +: 4] = 4'(fs[k]);
      bus.req_t[4*k +: 4] = 4'(ft[k]);
    end
    bus.req_valid  = '1;
    bus.resp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      g = m_ptr;
      #1;
      chk("fair_grant", bus.req_ready, 32'(1) << g);
      for (int c = 1; c <= 3; c++) begin
        @(posedge clk); #1;
        chk("fair_ready_low", bus.req_ready, 0);
        chk("fair_valid", bus.resp_valid, (c == 3) ? 1 : 0);
      end
      chk("fair_id", bus.resp_id, g);
      chk("fair_ok", bus.resp_ok, ref_solvable(fs[g], ft[g]));
      @(posedge clk); #1;
      model_count(ref_solvable(fs[g], ft[g]), 1'b0);
      m_ptr = (g + 1) % NREQ;
      chk("fair_cnt_ok", cnt_ok, m_ok);
      chk("fair_cnt_fail", cnt_fail, m_fail);
    end
    bus.req_valid  = '0;
    bus.resp_ready = 1'b0;

    // Reset during EVAL aborts the query and restarts arbitration at 0.
    bus.req_valid = 4'b0100;
    #1;
    chk("abort_grant", bus.req_ready, 4'b0100);
    @(posedge clk); #1;
    bus.req_valid = '0;
    rst = 1'b1;
    #1;
    chk_zero("abort_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    m_ok = 0; m_fail = 0; m_ptr = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("abort_no_resp", bus.resp_valid, 0);
    end
    bus.req_valid = '1;
    #1;
    chk("after_reset_grant", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("after_reset_valid", bus.resp_valid, 1);
    chk("after_reset_id", bus.resp_id, 0);
    chk("after_reset_ok", bus.resp_ok, ref_solvable(fs[0], ft[0]));
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;

    // Two-bit counters saturate after three solved responses.
    bus2.req_s[3:0] = 4'd0;
    bus2.req_t[3:0] = 4'($urandom_range(0, 15));
    bus2.req_valid  = 4'b0001;
    bus2.resp_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("sat_cnt_ok_2", cnt_ok2, 2);
    repeat (12) @(posedge clk);
    #1;
    chk("sat_cnt_ok_3", cnt_ok2, 3);
    chk("sat_cnt_fail", cnt_fail2, 0);
    bus2.req_valid  = '0;
    bus2.resp_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
